// File: rtl/screen_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
//   Shared types and constants for the full-screen overlay block:
//     state_t      - overlay FSM states (IDLE, ARM, LISTEN, DONE)
//     done_code_t  - exit code reported alongside the done pulse
//     KEY_SCOLON / KEY_ENTER - keyboard scan codes used as default exit keys
// -----------------------------------------------------------------------------
package screen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        LISTEN = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CODE_NONE    = 2'b00,
        CODE_CONFIRM = 2'b01,
        CODE_ALT     = 2'b10,
        CODE_TIMEOUT = 2'b11
    } done_code_t;

    localparam logic [8:0] KEY_SCOLON = 9'h04C;
    localparam logic [8:0] KEY_ENTER  = 9'h05A;

    // Blink phase flips once every 2**BLINK_LOG2 frames.
    localparam int BLINK_LOG2 = 5;

endpackage

// File: rtl/screen_addr_gen.sv
// -----------------------------------------------------------------------------
// screen_addr_gen
//   Maps the VGA raster onto a stored, upscaled image and produces the ROM
//   address plus a blank flag delayed to line up with the ROM read data.
//
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset
//     pix_ce     - pixel-rate enable; address and first blank stage move on it
//     h_cnt/v_cnt- VGA raster position
//     vid_valid  - VGA active-video flag
//     idle       - overlay FSM is in IDLE (forces blank)
//     hide       - extra blank request (prompt blink), sampled with the raster
//     sel_q      - latched image index, selects the image base address
//     rom_addr   - registered ROM address (holds when outside the image)
//     blank_d    - blank flag aligned with rom_data (one clk after rom_addr)
// -----------------------------------------------------------------------------
module screen_addr_gen #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 17,
    parameter int SEL_W       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              vid_valid,
    input  logic              idle,
    input  logic              hide,
    input  logic [SEL_W-1:0]  sel_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              blank_d
);

    localparam int IMG_W_PIX = IMG_W << SCALE_SHIFT;
    localparam int IMG_H_PIX = IMG_H << SCALE_SHIFT;
    localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_PIX_A = ADDR_W'(IMG_W * IMG_H);

    logic              in_image;
    logic [9:0]        img_col;
    logic [9:0]        img_row;
    logic [ADDR_W-1:0] addr_next;
    logic              blank_now;
    logic              blank_q;

    assign in_image = (int'(h_cnt) < IMG_W_PIX) && (int'(v_cnt) < IMG_H_PIX);
    assign img_col  = h_cnt >> SCALE_SHIFT;
    assign img_row  = v_cnt >> SCALE_SHIFT;

    // Every term is widened to ADDR_W before the arithmetic so the image base
    // and row offset cannot wrap at a narrower intermediate width.
    assign addr_next = ADDR_W'(sel_q) * IMG_PIX_A
                     + ADDR_W'(img_col)
                     + IMG_W_A * ADDR_W'(img_row);

    assign blank_now = !vid_valid || !in_image || idle || hide;

    // NOTE: the ROM array itself has no reset; only this address/flag pipeline
    // is reset, and the blank flags come up set so nothing leaks out early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            blank_q  <= 1'b1;
            blank_d  <= 1'b1;
        end else begin
            if (pix_ce) begin
                blank_q <= blank_now;
                if (in_image) begin
                    rom_addr <= addr_next;
                end
            end
            // Second stage tracks the ROM's one-clk read latency.
            blank_d <= blank_q;
        end
    end

endmodule

// File: rtl/screen_overlay.sv
// -----------------------------------------------------------------------------
// screen_overlay
//   Full-screen overlay (fail / win / pause screens). Upscales one of N_IMAGES
//   images from an external 1-clk-latency ROM onto the 640x480 raster, then
//   waits for a confirm key, an alternate key or a frame timeout and reports
//   the exit with a one-clk done pulse and a held done_code.
//
//   Optional build macro SCREEN_OVERLAY_BLINK_EN: blinks the image-row band
//   PROMPT_Y0..PROMPT_Y1 every 32 frames while the overlay is active.
//
//   Ports:
//     clk, rst              - clock, asynchronous active-high reset
//     pix_ce                - pixel-rate enable
//     en                    - overlay active (from game FSM)
//     img_sel               - image index, latched on entry to ARM
//     h_cnt, v_cnt          - VGA raster counters
//     vid_valid             - VGA active-video flag
//     key_ready, keydown,
//     last_change           - keyboard decoder outputs
//     rom_addr / rom_data   - external image ROM interface
//     pixel                 - pixel to the VGA mux (3 clk behind h/v)
//     done, done_code       - exit pulse and exit code (01/10/11, 00 = none)
// -----------------------------------------------------------------------------
module screen_overlay
    import screen_pkg::*;
#(
    parameter int         IMG_W          = 160,
    parameter int         IMG_H          = 120,
    parameter int         SCALE_SHIFT    = 2,
    parameter int         N_IMAGES       = 2,
    parameter int         ADDR_W         = 17,
    parameter int         PIX_W          = 12,
    parameter logic [8:0] KEY_CONFIRM    = KEY_SCOLON,
    parameter logic [8:0] KEY_ALT        = KEY_ENTER,
    parameter int         TIMEOUT_FRAMES = 600,
    parameter int         PROMPT_Y0      = 96,
    parameter int         PROMPT_Y1      = 111,
    localparam int        SEL_W          = (N_IMAGES > 1) ? $clog2(N_IMAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic              en,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              vid_valid,
    input  logic              key_ready,
    input  logic              keydown,
    input  logic [8:0]        last_change,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  pixel,
    output logic              done,
    output logic [1:0]        done_code
);

    // The counter only has to reach TIMEOUT_FRAMES-1, where it saturates.
    localparam int CNT_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES - 1 : 0);

    if (longint'(N_IMAGES) * IMG_W * IMG_H > (longint'(1) << ADDR_W)) begin : g_rom_size_check
        $error("screen_overlay: N_IMAGES*IMG_W*IMG_H exceeds 2**ADDR_W");
    end

    if (PROMPT_Y0 > PROMPT_Y1) begin : g_prompt_check
        $error("screen_overlay: PROMPT_Y0 must not exceed PROMPT_Y1");
    end

    state_t           state_q, state_d;
    done_code_t       code_q, code_d, exit_code;
    logic             done_d;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_start;
    logic             arm_entry;
    logic             timeout_hit;
    logic             hide;
    logic             blank_d;

    assign frame_start = pix_ce && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign arm_entry   = (state_q == IDLE) && en;
    assign timeout_hit = (TIMEOUT_FRAMES != 0) && frame_start && (frame_cnt == CNT_LAST);
    assign done_code   = code_q;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        code_d    = code_q;
        done_d    = 1'b0;
        exit_code = CODE_NONE;

        // Priority: CONFIRM over ALT, any key over TIMEOUT.
        if (key_ready && keydown && last_change == KEY_CONFIRM) begin
            exit_code = CODE_CONFIRM;
        end else if (key_ready && keydown && last_change == KEY_ALT) begin
            exit_code = CODE_ALT;
        end else if (timeout_hit) begin
            exit_code = CODE_TIMEOUT;
        end

        if (!en) begin
            // Abort from any state: no pulse, code cleared.
            state_d = IDLE;
            code_d  = CODE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    code_d  = CODE_NONE;
                end
                ARM: begin
                    // A key still held from gameplay must be released first.
                    if (!keydown) begin
                        state_d = LISTEN;
                    end
                end
                LISTEN: begin
                    if (exit_code != CODE_NONE) begin
                        state_d = DONE;
                        code_d  = exit_code;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    code_d  = CODE_NONE;
                end
            endcase
        end
    end

    // ------------------------------------------- image select, frame count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            frame_cnt <= '0;
        end else if (arm_entry) begin
            sel_q     <= img_sel;
            frame_cnt <= '0;
        end else if ((state_q == ARM || state_q == LISTEN) && frame_start
                     && frame_cnt != CNT_LAST) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------- prompt blink
`ifdef SCREEN_OVERLAY_BLINK_EN
    logic [BLINK_LOG2-1:0] blink_cnt;
    logic                  blink_hidden;
    logic [9:0]            img_row;

    assign img_row = v_cnt >> SCALE_SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (arm_entry) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (state_q != IDLE && frame_start) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) begin
                blink_hidden <= ~blink_hidden;
            end
        end
    end

    assign hide = blink_hidden && (int'(img_row) >= PROMPT_Y0)
                               && (int'(img_row) <= PROMPT_Y1);
`else
    assign hide = 1'b0;
`endif

    // -------------------------------------------------- address / pixel
    screen_addr_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .ADDR_W      (ADDR_W),
        .SEL_W       (SEL_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .vid_valid (vid_valid),
        .idle      (state_q == IDLE),
        .hide      (hide),
        .sel_q     (sel_q),
        .rom_addr  (rom_addr),
        .blank_d   (blank_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel <= '0;
        end else begin
            pixel <= blank_d ? '0 : rom_data;
        end
    end

endmodule

// File: tb/tb_screen_overlay.sv
// -----------------------------------------------------------------------------
// tb_screen_overlay
//   Directed bench for screen_overlay. Three instances share the stimulus:
//   u_dut (default timeout), u_t3 (TIMEOUT_FRAMES=3), u_t0 (timeout disabled).
//   Each instance has its own behavioural 1-clk-latency ROM.
// -----------------------------------------------------------------------------
module tb_screen_overlay;
    import screen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic        en;
    logic [0:0]  img_sel;
    logic [9:0]  h_cnt, v_cnt;
    logic        vid_valid;
    logic        key_ready, keydown;
    logic [8:0]  last_change;

    logic [16:0] addr_a, addr_b, addr_c;
    logic [11:0] data_a, data_b, data_c;
    logic [11:0] pix_a, pix_b, pix_c;
    logic        done_a, done_b, done_c;
    logic [1:0]  code_a, code_b, code_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Bench ROM contents: never zero, so a blanked pixel is distinguishable.
    function automatic logic [11:0] rom_word(input logic [16:0] a);
        logic [16:0] t;
        t = a * 17'd37 + 17'd11;
        return t[11:0] | 12'h001;
    endfunction

    always @(posedge clk) data_a <= rom_word(addr_a);
    always @(posedge clk) data_b <= rom_word(addr_b);
    always @(posedge clk) data_c <= rom_word(addr_c);

    screen_overlay u_dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .img_sel(img_sel),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .vid_valid(vid_valid),
        .key_ready(key_ready), .keydown(keydown), .last_change(last_change),
        .rom_addr(addr_a), .rom_data(data_a), .pixel(pix_a),
        .done(done_a), .done_code(code_a)
    );

    screen_overlay #(.TIMEOUT_FRAMES(3)) u_t3 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .img_sel(img_sel),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .vid_valid(vid_valid),
        .key_ready(key_ready), .keydown(keydown), .last_change(last_change),
        .rom_addr(addr_b), .rom_data(data_b), .pixel(pix_b),
        .done(done_b), .done_code(code_b)
    );

    screen_overlay #(.TIMEOUT_FRAMES(0)) u_t0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .img_sel(img_sel),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .vid_valid(vid_valid),
        .key_ready(key_ready), .keydown(keydown), .last_change(last_change),
        .rom_addr(addr_c), .rom_data(data_c), .pixel(pix_c),
        .done(done_c), .done_code(code_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic keys(input logic rdy, input logic down, input logic [8:0] code);
        key_ready   = rdy;
        keydown     = down;
        last_change = code;
    endtask

    task automatic raster(input logic [9:0] h, input logic [9:0] v, input logic vv);
        h_cnt     = h;
        v_cnt     = v;
        vid_valid = vv;
    endtask

    typedef struct {
        logic        sel;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vv;
        logic [16:0] exp_addr;
        logic        visible;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses_a, pulses_b, pulses_c;

        vecs[0] = '{1'b1, 10'd8,   10'd4,   1'b1, 17'd19362, 1'b1};
        vecs[1] = '{1'b1, 10'd4,   10'd0,   1'b1, 17'd19201, 1'b1};
        vecs[2] = '{1'b1, 10'd639, 10'd479, 1'b1, 17'd38399, 1'b1};
        vecs[3] = '{1'b1, 10'd640, 10'd479, 1'b1, 17'd38399, 1'b0};
        vecs[4] = '{1'b1, 10'd100, 10'd480, 1'b1, 17'd38399, 1'b0};
        vecs[5] = '{1'b1, 10'd20,  10'd40,  1'b0, 17'd20805, 1'b0};
        vecs[6] = '{1'b0, 10'd8,   10'd4,   1'b1, 17'd19362, 1'b1};
        vecs[7] = '{1'b0, 10'd3,   10'd3,   1'b1, 17'd19200, 1'b1};

        // ---------------- reset
        rst = 1'b1; pix_ce = 1'b1; en = 1'b0; img_sel = 1'b1;
        raster(10'd700, 10'd500, 1'b0);
        keys(1'b0, 1'b0, 9'h000);
        #12;
        check("reset_addr",  32'(addr_a), 0);
        check("reset_pixel", 32'(pix_a), 0);
        check("reset_done",  32'(done_a), 0);
        check("reset_code",  32'(code_a), 0);
        rst = 1'b0;
        tick();

        // ---------------- enter with image 1, then address table
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            img_sel = vecs[i].sel;
            raster(vecs[i].h, vecs[i].v, vecs[i].vv);
            repeat (3) tick();
            check($sformatf("vec%0d_addr", i), 32'(addr_a), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_pixel", i), 32'(pix_a),
                  vecs[i].visible ? 32'(rom_word(vecs[i].exp_addr)) : 32'd0);
        end

        // ---------------- pixel latency from steady 19200 to 19362
        raster(10'd8, 10'd4, 1'b1);
        tick();
        check("lat_addr_e0",  32'(addr_a), 19362);
        check("lat_pixel_e0", 32'(pix_a), 32'(rom_word(17'd19200)));
        tick();
        check("lat_pixel_e1", 32'(pix_a), 32'(rom_word(17'd19200)));
        tick();
        check("lat_pixel_e2", 32'(pix_a), 32'(rom_word(17'd19362)));

        // rom_addr only moves on pix_ce
        pix_ce = 1'b0;
        raster(10'd3, 10'd3, 1'b1);
        tick();
        tick();
        check("hold_no_ce", 32'(addr_a), 19362);
        pix_ce = 1'b1;

        // ---------------- confirm key
        keys(1'b1, 1'b1, KEY_SCOLON);
        tick();
        check("confirm_done", 32'(done_a), 1);
        check("confirm_code", 32'(code_a), 1);
        keys(1'b0, 1'b0, KEY_SCOLON);
        pulses_a = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) keys(1'b1, 1'b1, KEY_SCOLON);
            else        keys(1'b0, 1'b0, KEY_SCOLON);
            tick();
            if (done_a) pulses_a++;
        end
        check("confirm_single_pulse", 32'(pulses_a), 0);
        check("confirm_code_held", 32'(code_a), 1);

        // ---------------- abort from DONE, idle blanking
        en = 1'b0;
        tick();
        check("abort_done_code", 32'(code_a), 0);
        check("abort_done_pulse", 32'(done_a), 0);
        raster(10'd8, 10'd4, 1'b1);
        repeat (4) tick();
        check("idle_blank", 32'(pix_a), 0);

        // ---------------- held key on entry, image 0
        img_sel = 1'b0;
        keys(1'b1, 1'b1, KEY_SCOLON);
        en = 1'b1;
        tick();
        pulses_a = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_a) pulses_a++;
        end
        check("held_no_done", 32'(pulses_a), 0);
        check("img0_addr", 32'(addr_a), 162);
        keys(1'b0, 1'b0, KEY_SCOLON);
        tick();
        keys(1'b1, 1'b1, KEY_SCOLON);
        tick();
        check("held_repress_done", 32'(done_a), 1);
        check("held_repress_code", 32'(code_a), 1);
        keys(1'b0, 1'b0, 9'h000);

        // ---------------- abort in LISTEN with a key in the same cycle
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        keys(1'b1, 1'b1, KEY_SCOLON);
        tick();
        check("listen_abort_done", 32'(done_a), 0);
        check("listen_abort_code", 32'(code_a), 0);
        keys(1'b0, 1'b0, 9'h000);
        tick();
        check("listen_abort_done2", 32'(done_a), 0);

        // ---------------- timeout (u_t3) and disabled timeout (u_t0)
        raster(10'd700, 10'd500, 1'b0);
        en = 1'b1;
        tick();
        tick();
        pulses_a = 0; pulses_b = 0; pulses_c = 0;
        for (int f = 1; f <= 10; f++) begin
            raster(10'd0, 10'd0, 1'b1);
            tick();
            if (done_a) pulses_a++;
            if (done_b) pulses_b++;
            if (done_c) pulses_c++;
            if (f < 3) check($sformatf("t3_early_f%0d", f), 32'(done_b), 0);
            if (f == 3) begin
                check("t3_done", 32'(done_b), 1);
                check("t3_code", 32'(code_b), 3);
            end
            raster(10'd700, 10'd500, 1'b0);
            repeat (2) begin
                tick();
                if (done_a) pulses_a++;
                if (done_b) pulses_b++;
                if (done_c) pulses_c++;
            end
        end
        check("t3_one_pulse", 32'(pulses_b), 1);
        check("t3_code_held", 32'(code_b), 3);
        check("t0_no_pulse", 32'(pulses_c), 0);
        check("t0_code", 32'(code_c), 0);
        check("t600_no_pulse", 32'(pulses_a), 0);

        // ---------------- ALT and timeout in the same cycle, then reset in DONE
        en = 1'b0;
        tick();
        img_sel = 1'b1;
        en = 1'b1;
        tick();
        tick();
        repeat (2) begin
            raster(10'd0, 10'd0, 1'b1);
            tick();
            raster(10'd700, 10'd500, 1'b0);
            tick();
        end
        raster(10'd0, 10'd0, 1'b1);
        keys(1'b1, 1'b1, KEY_ENTER);
        tick();
        check("simul_t3_done", 32'(done_b), 1);
        check("simul_t3_code", 32'(code_b), 2);
        check("simul_dut_code", 32'(code_a), 2);
        check("simul_addr", 32'(addr_a), 19200);
        rst = 1'b1;
        #2;
        check("rst_done",  32'(done_a), 0);
        check("rst_code",  32'(code_a), 0);
        check("rst_addr",  32'(addr_a), 0);
        check("rst_pixel", 32'(pix_a), 0);
        check("rst_t3_done", 32'(done_b), 0);
        check("rst_t3_code", 32'(code_b), 0);
        keys(1'b0, 1'b0, 9'h000);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
